// File: rtl/mux_logic_pkg.sv
// rtl/mux_logic_pkg.sv - shared op codes and widths for the mux-built logic pipeline
package mux_logic_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_t;

    localparam int CNT_W = 16;

endpackage

// File: rtl/mux_logic_bit.sv
// rtl/mux_logic_bit.sv - one-bit AND/OR/XOR/NAND unit built only from 2:1 mux instances
module mux_logic_mux2 (
    input  logic d0,
    input  logic d1,
    input  logic s,
    output logic y
);
    assign y = s ? d1 : d0;
endmodule

module mux_logic_bit (
    input  logic       a,
    input  logic       b,
    input  logic [1:0] op,
    output logic       y
);
    logic y_and;
    logic y_or;
    logic not_a;
    logic y_xor;
    logic y_nand;
    logic sel_lo;
    logic sel_hi;

    mux_logic_mux2 u_and   (.d0(1'b0),  .d1(a),      .s(b),     .y(y_and));
    mux_logic_mux2 u_or    (.d0(a),     .d1(1'b1),   .s(b),     .y(y_or));
    mux_logic_mux2 u_not_a (.d0(1'b1),  .d1(1'b0),   .s(a),     .y(not_a));
    mux_logic_mux2 u_xor   (.d0(a),     .d1(not_a),  .s(b),     .y(y_xor));
    mux_logic_mux2 u_nand  (.d0(1'b1),  .d1(1'b0),   .s(y_and), .y(y_nand));

    // op[0] picks within each pair, op[1] picks the pair
    mux_logic_mux2 u_sel_lo (.d0(y_and),  .d1(y_or),   .s(op[0]), .y(sel_lo));
    mux_logic_mux2 u_sel_hi (.d0(y_xor),  .d1(y_nand), .s(op[0]), .y(sel_hi));
    mux_logic_mux2 u_sel    (.d0(sel_lo), .d1(sel_hi), .s(op[1]), .y(y));

endmodule

// File: rtl/mux_logic_pipe.sv
// rtl/mux_logic_pipe.sv - two-stage valid/ready mux-logic pipeline; MUX_LOGIC_PIPE_PARITY_EN adds out_parity
module mux_logic_pipe
    import mux_logic_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_res,
    output logic [1:0]       out_op,
`ifdef MUX_LOGIC_PIPE_PARITY_EN
    output logic             out_parity,
`endif
    output logic [CNT_W-1:0] out_cnt
);

    logic             s1_valid_q, s1_valid_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    op_t              op_q, op_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_res_q, out_res_d;
    op_t              out_op_q, out_op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             advance;
    logic             accept;
    logic [W-1:0]     res_w;

    assign advance  = !out_valid_q | out_ready;
    assign in_ready = rst & (!s1_valid_q | advance);
    assign accept   = in_valid & in_ready;

    for (genvar i = 0; i < W; i++) begin : g_bit
        mux_logic_bit u_bit (
            .a  (a_q[i]),
            .b  (b_q[i]),
            .op (op_q),
            .y  (res_w[i])
        );
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_op_d    = out_op_q;
        cnt_d       = cnt_q;

        // operands are only captured on a handshake, so idle X never reaches S1
        if (accept) begin
            s1_valid_d = 1'b1;
            a_d        = in_a;
            b_d        = in_b;
            op_d       = op_t'(in_op);
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end

        if (advance) begin
            out_valid_d = s1_valid_q;
            out_res_d   = res_w;
            out_op_d    = op_q;
        end

        if (out_valid_q & out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_AND;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_op_q    <= OP_AND;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_op_q    <= out_op_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_res   = out_res_q;
    assign out_op    = out_op_q;
    assign out_cnt   = cnt_q;

`ifdef MUX_LOGIC_PIPE_PARITY_EN
    logic [W-1:0] par_chain;
    logic         parity_q;

    // XOR chain reuses the bit unit with its op tied to XOR
    assign par_chain[0] = res_w[0];
    for (genvar i = 1; i < W; i++) begin : g_par
        mux_logic_bit u_par (
            .a  (par_chain[i-1]),
            .b  (res_w[i]),
            .op (OP_XOR),
            .y  (par_chain[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else if (advance) begin
            parity_q <= par_chain[W-1];
        end
    end

    assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_logic_pipe.sv
// tb/tb_mux_logic_pipe.sv - scoreboard bench for mux_logic_pipe
module tb_mux_logic_pipe;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic [1:0]   op;
        logic         par;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [1:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic [1:0]   out_op;
    logic [15:0]  out_cnt;
`ifdef MUX_LOGIC_PIPE_PARITY_EN
    logic         out_parity;
`endif

    int           n_tests = 0;
    int           n_fail  = 0;
    exp_t         sb[$];
    logic [15:0]  cnt_model = 16'd0;

    always #5 clk = ~clk;

    mux_logic_pipe #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_op     (out_op),
`ifdef MUX_LOGIC_PIPE_PARITY_EN
        .out_parity (out_parity),
`endif
        .out_cnt    (out_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    // handshakes are observed mid-cycle; they complete at the following rising edge
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_out", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("sb_res", 32'(out_res), 32'(e.res));
                check_eq("sb_op", 32'(out_op), 32'(e.op));
                check_eq("sb_cnt", 32'(out_cnt), 32'(cnt_model));
`ifdef MUX_LOGIC_PIPE_PARITY_EN
                check_eq("sb_parity", 32'(out_parity), 32'(e.par));
`endif
            end
            cnt_model = cnt_model + 16'd1;
        end
        if (rst === 1'b1 && in_valid === 1'b1 && in_ready === 1'b1) begin
            e.res = model(in_a, in_b, in_op);
            e.op  = in_op;
            e.par = ^e.res;
            sb.push_back(e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
    endtask

    logic [W-1:0] held_res;
    logic [W-1:0] exp4 [4];

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_a      = 'x;
        in_b      = 'x;
        in_op     = 'x;
        out_ready = 1'b0;
        repeat (3) tick();

        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_res", 32'(out_res), 32'd0);
        check_eq("rst_out_cnt", 32'(out_cnt), 32'd0);
        rst = 1'b1;
        #1;
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

        // single AND beat
        out_ready = 1'b1;
        set_beat(8'hF0, 8'h3C, 2'b00);
        tick();
        in_valid = 1'b0;
        in_a = 'x; in_b = 'x; in_op = 'x;
        check_eq("single_not_yet", 32'(out_valid), 32'd0);
        tick();
        check_eq("single_valid", 32'(out_valid), 32'd1);
        check_eq("single_res", 32'(out_res), 32'h30);
        check_eq("single_op", 32'(out_op), 32'd0);
        tick();
        check_eq("single_cnt", 32'(out_cnt), 32'd1);

        // all ops back-to-back
        exp4[0] = 8'h05; exp4[1] = 8'hAF; exp4[2] = 8'hAA; exp4[3] = 8'hFA;
        for (int i = 0; i < 4; i++) begin
            set_beat(8'hA5, 8'h0F, 2'(i));
            tick();
            if (i > 0) begin
                check_eq("b2b_valid", 32'(out_valid), 32'd1);
                check_eq("b2b_res", 32'(out_res), 32'(exp4[i-1]));
            end
        end
        in_valid = 1'b0;
        tick();
        check_eq("b2b_valid_last", 32'(out_valid), 32'd1);
        check_eq("b2b_res_last", 32'(out_res), 32'(exp4[3]));
        tick();
        check_eq("b2b_idle", 32'(out_valid), 32'd0);

        // backpressure: capacity of two, third beat waits for out_ready
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_beat(W'($urandom), W'($urandom), 2'($urandom));
            #1;
            check_eq("bp_accept", 32'(in_ready), 32'd1);
            tick();
        end
        set_beat(W'($urandom), W'($urandom), 2'($urandom));
        #1;
        check_eq("bp_third_blocked", 32'(in_ready), 32'd0);
        held_res = out_res;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("bp_hold_res", 32'(out_res), 32'(held_res));
            check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
            check_eq("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_ready_comb", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check_eq("bp_drained", 32'(sb.size()), 32'd0);

        // mid-stream reset with two beats in flight
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_beat(W'($urandom), W'($urandom), 2'($urandom));
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("mrst_in_ready_comb", 32'(in_ready), 32'd0);
        tick();
        check_eq("mrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mrst_out_cnt", 32'(out_cnt), 32'd0);
        check_eq("mrst_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        cnt_model = 16'd0;
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        check_eq("mrst_in_ready_after", 32'(in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("mrst_no_stale", 32'(out_valid), 32'd0);
        end

        // counter wrap after 65537 deliveries
        for (int k = 0; k < 65537; k++) begin
            set_beat(W'($urandom), W'($urandom), 2'($urandom));
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        check_eq("wrap_cnt", 32'(out_cnt), 32'd1);
        check_eq("wrap_drained", 32'(sb.size()), 32'd0);

        // XOR corner with parity
        set_beat(8'hFF, 8'h01, 2'b10);
        tick();
        in_valid = 1'b0;
        tick();
        check_eq("xor_res", 32'(out_res), 32'hFE);
`ifdef MUX_LOGIC_PIPE_PARITY_EN
        check_eq("xor_parity", 32'(out_parity), 32'd1);
`endif
        repeat (2) tick();
        check_eq("final_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_logic_pipe.md
# mux_logic_pipe

Two-stage valid/ready pipeline that applies a selectable bitwise logic operation (AND, OR, XOR, NAND) to two W-bit operands. Every result bit is produced only by 2:1 mux instances, constant 0/1 and wires, with no behavioural logic operators. It sits directly downstream of the single-bit mux-built gates and consumes them as its datapath. Upstream producers stream operand pairs in; a downstream consumer drains results with backpressure.

## Interface
- W, default 8: operand and result width, at least 1.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset (0 = reset).
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result this cycle.
- out_res  output  W  result.
- out_op  output  2  op code that produced out_res.
- out_cnt  output  16  count of delivered results (out_valid & out_ready), wraps at 2^16.
- out_parity  output  1  even parity (XOR-reduce) of out_res; present only under the macro.

## Operation
- S1 (operand register) holds s1_valid, a, b and op.
- S2 (result register) holds out_valid, out_res and out_op.
- advance = !out_valid | out_ready.
- in_ready = rst & (!s1_valid | advance). This is combinational from out_ready; there is no skid buffer.
- Accept = in_valid & in_ready. On accept, S1 loads the inputs and s1_valid = 1.
- If S1 moves on to S2 with no new accept, s1_valid = 0.
- On advance, S2 loads the op applied to the S1 operands, out_op = S1 op, and out_valid = s1_valid.
- When !advance, S1 and S2 hold their values and out_res is stable while out_valid & !out_ready.
- Per-bit op built from muxes only:
  - AND = mux(0, a, b).
  - OR = mux(a, 1, b).
  - NOT a = mux(1, 0, a).
  - XOR = mux(a, NOT a, b).
  - NAND = NOT AND.
  - The final selection is a two-level mux tree on op[0] then op[1].
- out_cnt increments by 1 on each delivered beat and wraps from 16'hFFFF to 0.
- Reset (rst = 0 at a clock edge):
  - s1_valid = 0, out_valid = 0, out_res = 0, out_op = 0, out_cnt = 0.
  - in_ready = 0 while rst = 0.
  - Beats in flight are discarded with no partial output.
- Simultaneous accept and drain in one cycle is legal and sustains one beat per cycle.
- X on in_a/in_b/in_op while in_valid = 0 must not propagate into out_valid or out_cnt.

## Timing
- Latency: a beat accepted at edge N is visible on out_* after edge N+1, with out_valid high in the following cycle, when out_ready is held high.
- Throughput: 1 beat/cycle with out_ready = 1.
- Capacity: 2 beats (S1 + S2). With out_ready = 0 from reset, in_ready falls after the second accept.
- After out_ready returns to 1, in_ready is high in the same cycle (combinational path).
- After rst deasserts, in_ready = 1 in the first cycle.

## Configuration
- MUX_LOGIC_PIPE_PARITY_EN defined:
  - out_parity port exists, registered in S2 alongside out_res.
  - out_parity is the mux-built XOR chain over the result bits.
  - Reset value 0.
  - Holds under backpressure exactly like out_res.
- Macro undefined: port and logic absent. All other behaviour is identical.

## Structure
- Shared package mux_logic_pkg:
  - op_t enum: OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_NAND = 2'b11.
  - CNT_W = 16.
- Sub-module mux_logic_bit: one-bit op unit from 2:1 mux instances, ports a, b, op, y. The top generates W copies.
- Parity chain and pipeline registers live in the top module.

## Test plan
- Reset then single beat: W = 8, a = 8'hF0, b = 8'h3C, op = AND, out_ready = 1. Requires out_res = 8'h30 and out_op = 00 in the cycle after next, then out_cnt = 1.
- All ops back-to-back, one per cycle, with a = 8'hA5, b = 8'h0F:
  - out_res = 8'h05, 8'hAF, 8'hAA, 8'hFA in order.
  - out_valid is continuous for 4 cycles.
- Backpressure:
  - out_ready = 0, push 3 beats. Exactly 2 are accepted and in_ready = 0 on the third.
  - Raise out_ready. The results drain in order, the held out_res does not change while stalled, and the third beat is accepted in the cycle out_ready rises.
- Mid-stream reset: 2 beats in flight, rst = 0 for one cycle. Requires out_valid = 0, out_cnt = 0, in_ready = 0 during reset, and no stale result afterwards.
- Counter wrap: deliver 65537 beats. Requires out_cnt = 1.
- With MUX_LOGIC_PIPE_PARITY_EN: a = 8'hFF, b = 8'h01, op = XOR gives out_res = 8'hFE and out_parity = 1. Same run without the macro compiles with no out_parity port.
